// File: rtl/mdu_issue_if.sv
// Handshake bundle between E-stage control and the MDU issue sequencer.
interface mdu_issue_if;
    logic       e_valid;
    logic       e_flush;
    logic [3:0] e_op;
    logic       d_uses_mdu;
    logic       mdu_start;
    logic [3:0] mdu_op;
    logic       stall;
    logic       busy;
    logic [1:0] state;
    logic       err;

    modport master (
        output e_valid, e_flush, e_op, d_uses_mdu,
        input  mdu_start, mdu_op, stall, busy, state, err
    );

    modport slave (
        input  e_valid, e_flush, e_op, d_uses_mdu,
        output mdu_start, mdu_op, stall, busy, state, err
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// MDU issue sequencer: start pulse, latency countdown, D-stage stall
// and sticky error on attempts to use the unit while it is occupied.
module mdu_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input logic        clk,
    input logic        reset,
    mdu_issue_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic e_live;
    logic issue_ok;
    logic is_arith;
    logic is_mul;
    logic is_move;
    logic start;
    logic viol;

    always_comb begin
        e_live   = bus.e_valid & ~bus.e_flush;
        issue_ok = e_live & (state_q == IDLE) & ~reset;
        is_mul   = (bus.e_op == 4'd1) | (bus.e_op == 4'd2);
        is_arith = (bus.e_op >= 4'd1) & (bus.e_op <= 4'd4);
        is_move  = (bus.e_op >= 4'd5) & (bus.e_op <= 4'd8);
        start    = issue_ok & is_arith;
        viol     = e_live & (is_arith | is_move) & (state_q != IDLE);
    end

    // Reset gating keeps outputs quiet even though inputs may be live.
    always_comb begin
        bus.mdu_start = start;
        bus.mdu_op    = (issue_ok & (is_arith | is_move)) ? bus.e_op : 4'd0;
        bus.busy      = ~reset & (start | (state_q != IDLE));
        bus.stall     = bus.d_uses_mdu & bus.busy;
        bus.state     = state_q;
        bus.err       = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (viol)
                err_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= is_mul ? MUL : DIV;
                        count_q <= is_mul ? CNT_W'(MUL_LAT)
                                          : CNT_W'(DIV_LAT);
                    end
                end
                MUL, DIV: begin
                    if (count_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: issue, latency, stall, flush,
// move ops, protocol error and asynchronous reset.
module tb_mdu_issue_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mdu_issue_if bus ();

    mdu_issue_ctrl #(
        .MUL_LAT(5),
        .DIV_LAT(10),
        .CNT_W  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.e_valid    = 1'b0;
        bus.e_flush    = 1'b0;
        bus.e_op       = 4'd0;
        bus.d_uses_mdu = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.e_valid    = 1'b1;
        bus.e_op       = 4'd1;
        bus.d_uses_mdu = 1'b1;
        #2;
        checks++;
        if (bus.mdu_start !== 1'b0 || bus.mdu_op !== 4'd0) begin
            $display("FAIL reset_issue start=%0b op=%0d want 0/0",
                     bus.mdu_start, bus.mdu_op);
            failures++;
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            $display("FAIL reset_busy busy=%0b stall=%0b want 0/0",
                     bus.busy, bus.stall);
            failures++;
        end
        checks++;
        if (bus.state !== 2'd0 || bus.err !== 1'b0) begin
            $display("FAIL reset_state state=%0d err=%0b want 0/0",
                     bus.state, bus.err);
            failures++;
        end
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_mult();
        bus.e_valid = 1'b1;
        bus.e_op    = 4'd1;
        for (int c = 0; c <= 6; c++) begin
            #2;
            checks++;
            if (bus.mdu_start !== (c == 0)) begin
                $display("FAIL mult_start c=%0d got=%0b want=%0b",
                         c, bus.mdu_start, (c == 0));
                failures++;
            end
            checks++;
            if (bus.mdu_op !== ((c == 0) ? 4'd1 : 4'd0)) begin
                $display("FAIL mult_op c=%0d got=%0d", c, bus.mdu_op);
                failures++;
            end
            checks++;
            if (bus.busy !== (c <= 5)) begin
                $display("FAIL mult_busy c=%0d got=%0b want=%0b",
                         c, bus.busy, (c <= 5));
                failures++;
            end
            checks++;
            if (bus.state !== ((c >= 1 && c <= 5) ? 2'd1 : 2'd0)) begin
                $display("FAIL mult_state c=%0d got=%0d", c, bus.state);
                failures++;
            end
            tick();
            idle_inputs();
        end
    endtask

    task automatic test_div_stall();
        int starts;
        starts         = 0;
        bus.e_valid    = 1'b1;
        bus.e_op       = 4'd3;
        bus.d_uses_mdu = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            #2;
            if (bus.mdu_start === 1'b1)
                starts++;
            checks++;
            if (bus.stall !== (c <= 10)) begin
                $display("FAIL div_stall c=%0d got=%0b want=%0b",
                         c, bus.stall, (c <= 10));
                failures++;
            end
            tick();
            bus.e_valid = 1'b0;
            bus.e_op    = 4'd0;
        end
        checks++;
        if (starts != 1) begin
            $display("FAIL div_start_count got=%0d want=1", starts);
            failures++;
        end
        idle_inputs();
    endtask

    task automatic test_violation();
        bus.e_valid = 1'b1;
        bus.e_op    = 4'd1;
        tick();
        idle_inputs();
        tick();
        tick();
        bus.e_valid = 1'b1;
        bus.e_op    = 4'd5;
        #2;
        checks++;
        if (bus.mdu_op !== 4'd0 || bus.mdu_start !== 1'b0) begin
            $display("FAIL viol_drop op=%0d start=%0b want 0/0",
                     bus.mdu_op, bus.mdu_start);
            failures++;
        end
        checks++;
        if (bus.err !== 1'b0) begin
            $display("FAIL viol_err_early got=%0b want=0", bus.err);
            failures++;
        end
        tick();
        idle_inputs();
        #2;
        checks++;
        if (bus.err !== 1'b1 || bus.state !== 2'd1) begin
            $display("FAIL viol_err err=%0b state=%0d want 1/1",
                     bus.err, bus.state);
            failures++;
        end
        tick();
        tick();
        #2;
        checks++;
        if (bus.err !== 1'b1 || bus.state !== 2'd0) begin
            $display("FAIL viol_sticky err=%0b state=%0d want 1/0",
                     bus.err, bus.state);
            failures++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.err !== 1'b0) begin
            $display("FAIL viol_clear got=%0b want=0", bus.err);
            failures++;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_flush();
        bus.e_valid = 1'b1;
        bus.e_op    = 4'd4;
        bus.e_flush = 1'b1;
        #2;
        checks++;
        if (bus.mdu_start !== 1'b0 || bus.mdu_op !== 4'd0
            || bus.busy !== 1'b0) begin
            $display("FAIL flush_block start=%0b op=%0d busy=%0b want 0/0/0",
                     bus.mdu_start, bus.mdu_op, bus.busy);
            failures++;
        end
        tick();
        bus.e_flush = 1'b0;
        #2;
        checks++;
        if (bus.state !== 2'd0) begin
            $display("FAIL flush_state got=%0d want=0", bus.state);
            failures++;
        end
        checks++;
        if (bus.mdu_start !== 1'b1 || bus.mdu_op !== 4'd4) begin
            $display("FAIL flush_reissue start=%0b op=%0d want 1/4",
                     bus.mdu_start, bus.mdu_op);
            failures++;
        end
        tick();
        idle_inputs();
        for (int c = 1; c <= 10; c++)
            tick();
        #2;
        checks++;
        if (bus.state !== 2'd0 || bus.busy !== 1'b0) begin
            $display("FAIL divu_done state=%0d busy=%0b want 0/0",
                     bus.state, bus.busy);
            failures++;
        end
        tick();
    endtask

    task automatic test_moves();
        bus.e_valid    = 1'b1;
        bus.e_op       = 4'd8;
        bus.d_uses_mdu = 1'b1;
        #2;
        checks++;
        if (bus.mdu_op !== 4'd8 || bus.mdu_start !== 1'b0
            || bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            $display("FAIL mtlo op=%0d start=%0b busy=%0b stall=%0b want 8/0/0/0",
                     bus.mdu_op, bus.mdu_start, bus.busy, bus.stall);
            failures++;
        end
        tick();
        bus.e_op = 4'd6;
        #2;
        checks++;
        if (bus.mdu_op !== 4'd6 || bus.mdu_start !== 1'b0
            || bus.busy !== 1'b0 || bus.state !== 2'd0) begin
            $display("FAIL mflo op=%0d start=%0b busy=%0b state=%0d want 6/0/0/0",
                     bus.mdu_op, bus.mdu_start, bus.busy, bus.state);
            failures++;
        end
        tick();
        bus.e_op = 4'd12;
        #2;
        checks++;
        if (bus.mdu_op !== 4'd0 || bus.busy !== 1'b0) begin
            $display("FAIL op_none op=%0d busy=%0b want 0/0",
                     bus.mdu_op, bus.busy);
            failures++;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        bus.e_valid = 1'b1;
        bus.e_op    = 4'd3;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        bus.d_uses_mdu = 1'b1;
        #2;
        checks++;
        if (bus.stall !== 1'b1 || bus.state !== 2'd2) begin
            $display("FAIL areset_pre stall=%0b state=%0d want 1/2",
                     bus.stall, bus.state);
            failures++;
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.state !== 2'd0 || bus.busy !== 1'b0
            || bus.stall !== 1'b0) begin
            $display("FAIL areset_now state=%0d busy=%0b stall=%0b want 0/0/0",
                     bus.state, bus.busy, bus.stall);
            failures++;
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        test_mult();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_mult();
        test_div_stall();
        test_violation();
        test_flush();
        test_moves();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Sequences the multiply/divide unit for the 5-stage pipeline.
- Issues a one-cycle start for mult/multu/div/divu from the E stage and counts the unit's busy latency.
- Passes mfhi/mflo/mthi/mtlo to the unit only when it is idle, and stalls the D stage while a D-stage MDU instruction would collide with an operation in flight.
- Sits between E-stage decode/control and the MDU; owns the single source of truth for MDU occupancy.

Parameters:
- MUL_LAT, 5, busy cycles after the start cycle for mult/multu.
- DIV_LAT, 10, busy cycles after the start cycle for div/divu.
- CNT_W, 4, width of the latency down-counter; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- e_valid  input  1  E-stage instruction is valid.
- e_flush  input  1  E-stage instruction is being cancelled this cycle (exception/flush).
- e_op  input  4  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
- d_uses_mdu  input  1  D-stage instruction is any of opcodes 1-8.
- mdu_start  output  1  one-cycle start pulse to the MDU.
- mdu_op  output  4  op code presented to the MDU; 0 when nothing is issued.
- stall  output  1  freeze PC/F/D and insert a bubble into E.
- busy  output  1  MDU occupied: start cycle or counting.
- state  output  2  0 IDLE, 1 MUL, 2 DIV (debug/visibility).
- err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset: state=IDLE, count=0, err=0. While reset is high, mdu_start=0, mdu_op=0, stall=0 and busy=0, regardless of other inputs. Reset asserted mid-operation abandons the count immediately.
- issue_ok = e_valid & ~e_flush & (state==IDLE). All outputs except err are combinational from state, count and inputs, with zero latency.
- IDLE:
  - e_op in 1-4 with issue_ok: mdu_start=1, mdu_op=e_op, busy=1.
  - Next state is MUL with count=MUL_LAT for ops 1-2, or DIV with count=DIV_LAT for ops 3-4.
  - e_op in 5-8 with issue_ok: mdu_op=e_op, mdu_start=0, state stays IDLE.
  - Otherwise mdu_op=0.
- MUL/DIV:
  - busy=1, mdu_start=0, mdu_op=0.
  - count decrements each cycle. When count==1, the next state is IDLE with count=0.
  - busy therefore stays high for exactly 1+LAT cycles, counting the start cycle.
- stall = d_uses_mdu & busy. A D-stage MDU op issued in the cycle after a start therefore waits.
- e_flush=1 suppresses issue of the E-stage op: no start, mdu_op=0, no state change. A flush never cancels an operation already counting.
- Protocol violation: e_valid & ~e_flush & e_op in 1-8 while state!=IDLE.
  - Sets err=1; err is cleared only by reset.
  - The op is dropped: no start, mdu_op=0, the count is unaffected.
- The counter never wraps. It is only loaded in IDLE and decrements from LAT to 1.
- No back-to-back overlap: a new start is possible at the earliest in the cycle after the counter reaches 1, i.e. cycle start+LAT+1.

Test Plan:
- Reset then e_valid=1, e_op=1 at cycle 0 -> mdu_start=1 and mdu_op=1 at cycle 0 only; busy=1 for cycles 0-5; state=MUL for cycles 1-5 and IDLE at cycle 6.
- div (e_op=3) at cycle 0 with d_uses_mdu=1 held -> stall=1 for cycles 0-10 and 0 at cycle 11; mdu_start is asserted once.
- mult at cycle 0, then e_op=5 (mfhi) presented at cycle 3 -> err=1 from cycle 4, mdu_op=0, state still MUL; err persists until reset.
- e_valid=1, e_op=4, e_flush=1 -> mdu_start=0, mdu_op=0, busy=0, state stays IDLE; same op with e_flush=0 next cycle -> start issued.
- IDLE with e_op=8 (mtlo), then e_op=6 (mflo) -> mdu_op=8 then 6, mdu_start=0, busy=0, stall=0.
- div issued at cycle 0, reset pulsed asynchronously mid-cycle 4 -> state=IDLE, busy=0 and stall=0 immediately (before the next clock edge); a mult issued after reset release behaves as in the first scenario.
